// File: rtl/mips_pkg.sv
// Shared encodings for the write-back path: load-type codes and the
// hard-wired zero register.
package mips_pkg;

  localparam logic [2:0] LD_LW  = 3'd0;
  localparam logic [2:0] LD_LB  = 3'd1;
  localparam logic [2:0] LD_LBU = 3'd2;
  localparam logic [2:0] LD_LH  = 3'd3;
  localparam logic [2:0] LD_LHU = 3'd4;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/load_align.sv
// Little-endian load alignment: picks the addressed byte or halfword out of
// the raw memory word and sign- or zero-extends it. Unknown load types pass
// the word through unchanged.
module load_align
  import mips_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  ld_type,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Byte/half extraction; the low address bit is don't-care for halves
  always_comb begin
    byte_sel = rdata[7:0];
    case (addr_lo)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  // Extension according to load type
  always_comb begin
    data = rdata;
    case (ld_type)
      LD_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      LD_LBU:  data = {24'd0, byte_sel};
      LD_LH:   data = {{16{half_sel[15]}}, half_sel};
      LD_LHU:  data = {16'd0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: registers the register-file write port, choosing between
// the retiring pipeline instruction and late mul/div results. Pipeline writes
// always win; a mul/div result that collides with one is parked in a single
// holding slot and drained on the next cycle without a pipeline write.
module wb_stage
  import mips_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_valid,
  input  logic          mem_wen,
  input  logic [AW-1:0] mem_waddr,
  input  logic          mem_memtoreg,
  input  logic [DW-1:0] mem_alu_res,
  input  logic [DW-1:0] mem_rdata,
  input  logic [2:0]    mem_ld_type,
  input  logic [1:0]    mem_addr_lo,
  input  logic          md_valid,
  output logic          md_ready,
  input  logic [AW-1:0] md_waddr,
  input  logic [DW-1:0] md_wdata,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic          md_pend,
  output logic [AW-1:0] md_pend_waddr
);

  logic [DW-1:0] ld_data;
  logic [DW-1:0] pipe_wdata;
  logic          pipe_wr;
  logic          md_acc;
  logic          md_keep;

  logic          buf_valid;
  logic [AW-1:0] buf_waddr;
  logic [DW-1:0] buf_wdata;

  load_align u_load_align (
    .rdata   (mem_rdata),
    .addr_lo (mem_addr_lo),
    .ld_type (mem_ld_type),
    .data    (ld_data)
  );

  // Pipeline write qualification and mul/div handshake; $0 writes are dropped
  always_comb begin
    pipe_wdata = mem_memtoreg ? ld_data : mem_alu_res;
    pipe_wr    = mem_valid & mem_wen & (mem_waddr != '0);
    md_ready   = ~buf_valid;
    md_acc     = md_valid & md_ready;
    md_keep    = md_acc & (md_waddr != '0);
  end

  // Priority mux into the output register plus holding-buffer bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      buf_valid <= 1'b0;
      buf_waddr <= '0;
      buf_wdata <= '0;
    end else if (pipe_wr) begin
      rf_we    <= 1'b1;
      rf_waddr <= mem_waddr;
      rf_wdata <= pipe_wdata;
      // md_keep implies the buffer is empty, so it cannot overwrite an entry
      if (md_keep) begin
        buf_valid <= 1'b1;
        buf_waddr <= md_waddr;
        buf_wdata <= md_wdata;
      end
    end else if (buf_valid) begin
      rf_we     <= 1'b1;
      rf_waddr  <= buf_waddr;
      rf_wdata  <= buf_wdata;
      buf_valid <= 1'b0;
      buf_waddr <= '0;
    end else if (md_keep) begin
      rf_we    <= 1'b1;
      rf_waddr <= md_waddr;
      rf_wdata <= md_wdata;
    end else begin
      rf_we <= 1'b0;
    end
  end

  // Hazard-unit view of the holding slot
  always_comb begin
    md_pend       = buf_valid;
    md_pend_waddr = buf_waddr;
  end

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: each driven cycle pushes its expected register-file
// write onto a scoreboard, which is popped and compared after the edge.
module tb_wb_stage;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, mem_wen, mem_memtoreg;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_alu_res, mem_rdata;
  logic [2:0]  mem_ld_type;
  logic [1:0]  mem_addr_lo;
  logic        md_valid, md_ready;
  logic [4:0]  md_waddr;
  logic [31:0] md_wdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        md_pend;
  logic [4:0]  md_pend_waddr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic        chk;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        pend;
    logic [4:0]  pwaddr;
  } exp_t;

  exp_t sb[$];

  wb_stage #(.DW(32), .AW(5)) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_valid     (mem_valid),
    .mem_wen       (mem_wen),
    .mem_waddr     (mem_waddr),
    .mem_memtoreg  (mem_memtoreg),
    .mem_alu_res   (mem_alu_res),
    .mem_rdata     (mem_rdata),
    .mem_ld_type   (mem_ld_type),
    .mem_addr_lo   (mem_addr_lo),
    .md_valid      (md_valid),
    .md_ready      (md_ready),
    .md_waddr      (md_waddr),
    .md_wdata      (md_wdata),
    .rf_we         (rf_we),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata),
    .md_pend       (md_pend),
    .md_pend_waddr (md_pend_waddr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, push expectation, compare after posedge
  task automatic cyc(input string tag, input logic r,
                     input logic mv, input logic wen, input logic [4:0] wa,
                     input logic m2r, input logic [31:0] alu, input logic [31:0] rd,
                     input logic [2:0] lt, input logic [1:0] alo,
                     input logic mdv, input logic [4:0] mdw, input logic [31:0] mdd,
                     input logic ewe, input logic [4:0] ewa, input logic [31:0] ewd,
                     input logic epend, input logic [4:0] epwa);
    exp_t e, got;
    @(negedge clk);
    rst = r; mem_valid = mv; mem_wen = wen; mem_waddr = wa; mem_memtoreg = m2r;
    mem_alu_res = alu; mem_rdata = rd; mem_ld_type = lt; mem_addr_lo = alo;
    md_valid = mdv; md_waddr = mdw; md_wdata = mdd;
    e.we = ewe; e.chk = ewe | r; e.waddr = ewa; e.wdata = ewd;
    e.pend = epend; e.pwaddr = epwa;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, " sb_empty"}, 32'd1, 32'd0);
    end else begin
      got = sb.pop_front();
      check({tag, " rf_we"}, {31'd0, rf_we}, {31'd0, got.we});
      if (got.chk) begin
        check({tag, " rf_waddr"}, {27'd0, rf_waddr}, {27'd0, got.waddr});
        check({tag, " rf_wdata"}, rf_wdata, got.wdata);
      end
      check({tag, " md_pend"}, {31'd0, md_pend}, {31'd0, got.pend});
      check({tag, " md_ready"}, {31'd0, md_ready}, {31'd0, ~got.pend});
      if (got.pend)
        check({tag, " md_pend_waddr"}, {27'd0, md_pend_waddr}, {27'd0, got.pwaddr});
    end
  endtask

  localparam logic [31:0] RD = 32'h80FF7F01;

  initial begin
    rst = 1'b1; mem_valid = 0; mem_wen = 0; mem_waddr = 0; mem_memtoreg = 0;
    mem_alu_res = 0; mem_rdata = 0; mem_ld_type = LD_LW; mem_addr_lo = 0;
    md_valid = 0; md_waddr = 0; md_wdata = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset rf_we", {31'd0, rf_we}, 32'd0);
    check("reset rf_waddr", {27'd0, rf_waddr}, 32'd0);
    check("reset rf_wdata", rf_wdata, 32'd0);
    check("reset md_pend", {31'd0, md_pend}, 32'd0);
    check("reset md_pend_waddr", {27'd0, md_pend_waddr}, 32'd0);

    //  tag           rst mv wen wa  m2r alu           rdata         type    alo mdv mdw  mdd           we wa  wd            pend pwa
    cyc("ready_idle", 0,  0, 0,  0,  0,  0,            0,            LD_LW,  0,  0,  0,   0,            0, 0,  0,            0,   0);
    cyc("lw",         0,  1, 1,  5,  1,  32'h0,        32'h8899AABB, LD_LW,  0,  0,  0,   0,            1, 5,  32'h8899AABB, 0,   0);
    cyc("lb2",        0,  1, 1,  1,  1,  0,            RD,           LD_LB,  2,  0,  0,   0,            1, 1,  32'hFFFFFFFF, 0,   0);
    cyc("lbu3",       0,  1, 1,  2,  1,  0,            RD,           LD_LBU, 3,  0,  0,   0,            1, 2,  32'h00000080, 0,   0);
    cyc("lh2",        0,  1, 1,  3,  1,  0,            RD,           LD_LH,  2,  0,  0,   0,            1, 3,  32'hFFFF80FF, 0,   0);
    cyc("lhu0",       0,  1, 1,  4,  1,  0,            RD,           LD_LHU, 0,  0,  0,   0,            1, 4,  32'h00007F01, 0,   0);
    cyc("lh3",        0,  1, 1,  6,  1,  0,            RD,           LD_LH,  3,  0,  0,   0,            1, 6,  32'hFFFF80FF, 0,   0);
    cyc("lhu1",       0,  1, 1,  6,  1,  0,            RD,           LD_LHU, 1,  0,  0,   0,            1, 6,  32'h00007F01, 0,   0);
    cyc("lb0",        0,  1, 1,  7,  1,  0,            RD,           LD_LB,  0,  0,  0,   0,            1, 7,  32'h00000001, 0,   0);
    cyc("lbu1",       0,  1, 1,  8,  1,  0,            RD,           LD_LBU, 1,  0,  0,   0,            1, 8,  32'h0000007F, 0,   0);
    cyc("ld_undef",   0,  1, 1,  9,  1,  0,            RD,           3'd7,   2,  0,  0,   0,            1, 9,  RD,           0,   0);
    cyc("alu",        0,  1, 1,  2,  0,  32'h12345678, RD,           LD_LB,  1,  0,  0,   0,            1, 2,  32'h12345678, 0,   0);
    cyc("wr_r0",      0,  1, 1,  0,  0,  32'hCAFE,     0,            LD_LW,  0,  0,  0,   0,            0, 0,  0,            0,   0);
    cyc("no_valid",   0,  0, 1,  4,  0,  32'hCAFE,     0,            LD_LW,  0,  0,  0,   0,            0, 0,  0,            0,   0);
    cyc("no_wen",     0,  1, 0,  4,  0,  32'hCAFE,     0,            LD_LW,  0,  0,  0,   0,            0, 0,  0,            0,   0);
    cyc("md_r0",      0,  0, 0,  0,  0,  0,            0,            LD_LW,  0,  1,  0,   32'h55,       0, 0,  0,            0,   0);
    cyc("conf_c0",    0,  1, 1,  3,  0,  32'h11,       0,            LD_LW,  0,  1,  7,   32'h22,       1, 3,  32'h11,       1,   7);
    cyc("conf_c1",    0,  0, 0,  0,  0,  0,            0,            LD_LW,  0,  1,  8,   32'h33,       1, 7,  32'h22,       0,   0);
    cyc("conf_c2",    0,  0, 0,  0,  0,  0,            0,            LD_LW,  0,  1,  8,   32'h33,       1, 8,  32'h33,       0,   0);
    cyc("idle",       0,  0, 0,  0,  0,  0,            0,            LD_LW,  0,  0,  0,   0,            0, 0,  0,            0,   0);
    cyc("bypass",     0,  0, 0,  0,  0,  0,            0,            LD_LW,  0,  1,  9,   32'hDEAD,     1, 9,  32'hDEAD,     0,   0);
    cyc("hold_a",     0,  1, 1,  10, 0,  32'hA0,       0,            LD_LW,  0,  1,  11,  32'hB1,       1, 10, 32'hA0,       1,   11);
    cyc("hold_b",     0,  1, 1,  12, 0,  32'hA2,       0,            LD_LW,  0,  1,  13,  32'hB3,       1, 12, 32'hA2,       1,   11);
    cyc("hold_c",     0,  0, 0,  0,  0,  0,            0,            LD_LW,  0,  1,  13,  32'hB3,       1, 11, 32'hB1,       0,   0);
    cyc("hold_d",     0,  0, 0,  0,  0,  0,            0,            LD_LW,  0,  1,  13,  32'hB3,       1, 13, 32'hB3,       0,   0);
    cyc("p_md_r0",    0,  1, 1,  14, 0,  32'hC4,       0,            LD_LW,  0,  1,  0,   32'hD0,       1, 14, 32'hC4,       0,   0);
    cyc("rst_fill",   0,  1, 1,  14, 0,  32'hE4,       0,            LD_LW,  0,  1,  15,  32'hF5,       1, 14, 32'hE4,       1,   15);
    cyc("rst_mid",    1,  0, 0,  0,  0,  0,            0,            LD_LW,  0,  0,  0,   0,            0, 0,  0,            0,   0);
    cyc("rst_after",  0,  0, 0,  0,  0,  0,            0,            LD_LW,  0,  0,  0,   0,            0, 0,  0,            0,   0);
    cyc("rst_after2", 0,  0, 0,  0,  0,  0,            0,            LD_LW,  0,  0,  0,   0,            0, 0,  0,            0,   0);

    check("sb drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
